// File: rtl/event_synchronizer.sv
// ============================================================================
// event_synchronizer
// ----------------------------------------------------------------------------
// Brings CHANNELS asynchronous inputs (buttons, start/stop strobes, external
// handshakes) into the clk domain through a SYNC_STAGES flop chain. Each input
// can optionally be debounced. A selectable edge type on the resulting level
// produces a one-cycle pulse and a sticky pending flag that is held until it is
// acknowledged. A second event that arrives while pending is still set (and not
// being acknowledged) raises a sticky overrun flag.
//
// Parameters
//   CHANNELS         number of independent channels (>= 1)
//   SYNC_STAGES      synchronizer flops per channel (>= 2)
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a change, 0 = bypass
//   EDGE_MODE        0 = rising, 1 = falling, 2 = both edges create an event
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-low
//   asynch       in   raw asynchronous inputs
//   enable       in   1 = event detection active
//   ack          in   per-channel level that clears pending
//   overrun_clr  in   clears every overrun flag
//   synch        out  synchronized (and debounced) level
//   pulse        out  one-cycle event strobe
//   pending      out  sticky event flag
//   overrun      out  event arrived while pending was already set
//
// All outputs come straight from flops; every flop clears on rst==0.
// ============================================================================
module event_synchronizer #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_MODE       = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] asynch,
    input  logic                enable,
    input  logic [CHANNELS-1:0] ack,
    input  logic                overrun_clr,
    output logic [CHANNELS-1:0] synch,
    output logic [CHANNELS-1:0] pulse,
    output logic [CHANNELS-1:0] pending,
    output logic [CHANNELS-1:0] overrun
);

    localparam logic [1:0] EM = 2'(EDGE_MODE);

    // Synchronizer chain, one vector per stage; the last stage is the
    // metastability-safe sample of the raw input.
    logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
    logic [CHANNELS-1:0] w_s;

    // Synchronized/debounced level, edge history and event outputs.
    logic [CHANNELS-1:0] r_synch;
    logic [CHANNELS-1:0] r_prev;
    logic [CHANNELS-1:0] r_pulse;
    logic [CHANNELS-1:0] r_pending;
    logic [CHANNELS-1:0] r_overrun;

    // Edge decode.
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_fall;
    logic [CHANNELS-1:0] w_sel;
    logic [CHANNELS-1:0] w_event;

    // Shift the raw inputs through the synchronizer flops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= asynch;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // Without debounce the synchronized level is simply the last sync stage.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_synch <= '0;
                end else begin
                    r_synch <= w_s;
                end
            end
        end else begin : g_debounce
            localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);
            localparam logic [CW-1:0]  ONE  = CW'(1);

            logic [CW-1:0]       r_cnt [CHANNELS];
            logic [CHANNELS-1:0] r_stable;

            // Per-channel debounce: the counter measures how long the sampled
            // level has disagreed with the accepted (stable) level. The change
            // is accepted on the DEBOUNCE_CYCLES-th consecutive disagreement;
            // any agreement in between restarts the count, so shorter glitches
            // never reach r_stable. r_synch is the registered accepted level.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int ch = 0; ch < CHANNELS; ch++) begin
                        r_cnt[ch] <= '0;
                    end
                    r_stable <= '0;
                    r_synch  <= '0;
                end else begin
                    r_synch <= r_stable;
                    for (int ch = 0; ch < CHANNELS; ch++) begin
                        if (w_s[ch] != r_stable[ch]) begin
                            if (r_cnt[ch] == LAST) begin
                                r_stable[ch] <= w_s[ch];
                                r_cnt[ch]    <= '0;
                            end else begin
                                r_cnt[ch] <= r_cnt[ch] + ONE;
                            end
                        end else begin
                            r_cnt[ch] <= '0;
                        end
                    end
                end
            end
        end
    endgenerate

    // Edge decode against the previous level and gating with enable. Because
    // r_prev follows r_synch even while disabled, an edge seen during
    // enable=0 is consumed and can never fire later.
    always_comb begin
        w_rise = r_synch & ~r_prev;
        w_fall = ~r_synch & r_prev;
        case (EM)
            2'd0:    w_sel = w_rise;
            2'd1:    w_sel = w_fall;
            2'd2:    w_sel = w_rise | w_fall;
            default: w_sel = w_rise;
        endcase
        w_event = w_sel & {CHANNELS{enable}};
    end

    // Edge history, event strobe and the sticky pending/overrun flags.
    // An event that coincides with ack replaces the acknowledged one, so it
    // neither clears pending nor counts as an overrun. A new overrun wins over
    // overrun_clr in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev    <= '0;
            r_pulse   <= '0;
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_prev    <= r_synch;
            r_pulse   <= w_event;
            r_pending <= w_event | (r_pending & ~ack);
            r_overrun <= (w_event & r_pending & ~ack) |
                         (r_overrun & ~{CHANNELS{overrun_clr}});
        end
    end

    assign synch   = r_synch;
    assign pulse   = r_pulse;
    assign pending = r_pending;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_event_synchronizer.sv
// ============================================================================
// tb_event_synchronizer
// Two instances share one stimulus: dut_a (no debounce, rising edge) and
// dut_b (DEBOUNCE_CYCLES=4, both edges). A cycle model predicts every output
// of both instances; predictions are queued at each clock edge and compared at
// the following falling edge. Directed scenarios add timing and event-count
// checks on top of the scoreboard.
// ============================================================================
module tb_event_synchronizer;

    logic       clk;
    logic       rst;
    logic [3:0] asynch;
    logic       enable;
    logic [3:0] ack;
    logic       overrun_clr;

    logic [3:0] synch_a, pulse_a, pending_a, overrun_a;
    logic [3:0] synch_b, pulse_b, pending_b, overrun_b;

    event_synchronizer #(
        .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .asynch(asynch), .enable(enable), .ack(ack),
        .overrun_clr(overrun_clr), .synch(synch_a), .pulse(pulse_a),
        .pending(pending_a), .overrun(overrun_a)
    );

    event_synchronizer #(
        .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .asynch(asynch), .enable(enable), .ack(ack),
        .overrun_clr(overrun_clr), .synch(synch_b), .pulse(pulse_b),
        .pending(pending_b), .overrun(overrun_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         M_DEB [2] = '{0, 4};
    int         M_EM  [2] = '{0, 2};
    logic [3:0] m_c0 [2], m_c1 [2], m_stable [2], m_synch [2], m_prev [2];
    logic [3:0] m_pulse [2], m_pend [2], m_ovr [2];
    int         m_run [2][4];
    logic [31:0] exp_q [$];
    int pc_a [4];
    int pc_b [4];

    task model_step();
        logic [3:0] s, ns, rise, fall, sel, ev;
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                m_c0[d] = 4'h0; m_c1[d] = 4'h0; m_stable[d] = 4'h0; m_synch[d] = 4'h0;
                m_prev[d] = 4'h0; m_pulse[d] = 4'h0; m_pend[d] = 4'h0; m_ovr[d] = 4'h0;
                for (int ch = 0; ch < 4; ch++) m_run[d][ch] = 0;
            end else begin
                s  = m_c1[d];
                ns = (M_DEB[d] == 0) ? s : m_stable[d];
                if (M_DEB[d] != 0) begin
                    for (int ch = 0; ch < 4; ch++) begin
                        if (s[ch] != m_stable[d][ch]) begin
                            m_run[d][ch]++;
                            if (m_run[d][ch] == M_DEB[d]) begin
                                m_stable[d][ch] = s[ch];
                                m_run[d][ch] = 0;
                            end
                        end else begin
                            m_run[d][ch] = 0;
                        end
                    end
                end
                rise = m_synch[d] & ~m_prev[d];
                fall = ~m_synch[d] & m_prev[d];
                case (M_EM[d])
                    0:       sel = rise;
                    1:       sel = fall;
                    default: sel = rise | fall;
                endcase
                ev = sel & {4{enable}};
                m_ovr[d]   = (ev & m_pend[d] & ~ack) | (m_ovr[d] & ~{4{overrun_clr}});
                m_pend[d]  = ev | (m_pend[d] & ~ack);
                m_pulse[d] = ev;
                m_prev[d]  = m_synch[d];
                m_synch[d] = ns;
                m_c1[d]    = m_c0[d];
                m_c0[d]    = asynch;
            end
        end
    endtask

    // One clock: predict at the rising edge, compare at the falling edge.
    task step();
        logic [31:0] e;
        @(posedge clk);
        model_step();
        exp_q.push_back({m_synch[0], m_pulse[0], m_pend[0], m_ovr[0],
                         m_synch[1], m_pulse[1], m_pend[1], m_ovr[1]});
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val("sb_a_synch",   {28'd0, synch_a},   {28'd0, e[31:28]});
            check_val("sb_a_pulse",   {28'd0, pulse_a},   {28'd0, e[27:24]});
            check_val("sb_a_pending", {28'd0, pending_a}, {28'd0, e[23:20]});
            check_val("sb_a_overrun", {28'd0, overrun_a}, {28'd0, e[19:16]});
            check_val("sb_b_synch",   {28'd0, synch_b},   {28'd0, e[15:12]});
            check_val("sb_b_pulse",   {28'd0, pulse_b},   {28'd0, e[11:8]});
            check_val("sb_b_pending", {28'd0, pending_b}, {28'd0, e[7:4]});
            check_val("sb_b_overrun", {28'd0, overrun_b}, {28'd0, e[3:0]});
        end
        for (int ch = 0; ch < 4; ch++) begin
            pc_a[ch] += int'(pulse_a[ch]);
            pc_b[ch] += int'(pulse_b[ch]);
        end
    endtask

    task steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Let everything propagate, then acknowledge and clear all flags.
    task settle();
        steps(12);
        ack = 4'hF; overrun_clr = 1'b1;
        step();
        ack = 4'h0; overrun_clr = 1'b0;
        step();
    endtask

    int base0, base1, base2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int ch = 0; ch < 4; ch++) begin pc_a[ch] = 0; pc_b[ch] = 0; end
        rst = 1'b0; asynch = 4'h0; enable = 1'b1; ack = 4'h0; overrun_clr = 1'b0;
        steps(3);
        check_val("reset_a", {16'd0, synch_a, pulse_a, pending_a, overrun_a}, 32'd0);
        check_val("reset_b", {16'd0, synch_b, pulse_b, pending_b, overrun_b}, 32'd0);
        rst = 1'b1;
        steps(3);

        // 1: latency without debounce
        asynch[0] = 1'b1;
        steps(2);
        check_val("t1_synch_before", {31'd0, synch_a[0]}, 32'd0);
        step();
        check_val("t1_synch_edge2", {31'd0, synch_a[0]}, 32'd1);
        check_val("t1_pulse_edge2", {31'd0, pulse_a[0]}, 32'd0);
        step();
        check_val("t1_pulse_edge3",   {31'd0, pulse_a[0]},   32'd1);
        check_val("t1_pending_edge3", {31'd0, pending_a[0]}, 32'd1);
        step();
        check_val("t1_pulse_once", {31'd0, pulse_a[0]}, 32'd0);
        asynch[0] = 1'b0;
        settle();

        // 2: debounce drops a 3-cycle glitch, accepts a 6-cycle level
        base1 = pc_b[1];
        asynch[1] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) asynch[1] = 1'b0;
            step();
            check_val("t2_glitch_synch", {31'd0, synch_b[1]}, 32'd0);
        end
        check_val("t2_glitch_pulses",  pc_b[1] - base1, 32'd0);
        check_val("t2_glitch_pending", {31'd0, pending_b[1]}, 32'd0);
        asynch[1] = 1'b1;
        steps(6);
        check_val("t2_synch_early", {31'd0, synch_b[1]}, 32'd0);
        asynch[1] = 1'b0;
        step();
        check_val("t2_synch_edge6", {31'd0, synch_b[1]}, 32'd1);
        steps(12);
        check_val("t2_both_edges", pc_b[1] - base1, 32'd2);
        settle();

        // 3: both-edge mode, overrun and overrun_clr
        base2 = pc_b[2];
        asynch[2] = 1'b1;
        steps(10);
        asynch[2] = 1'b0;
        steps(12);
        check_val("t3_pulses",  pc_b[2] - base2, 32'd2);
        check_val("t3_pending", {31'd0, pending_b[2]}, 32'd1);
        check_val("t3_overrun", {31'd0, overrun_b[2]}, 32'd1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check_val("t3_overrun_clr", {31'd0, overrun_b[2]}, 32'd0);
        check_val("t3_pending_kept", {31'd0, pending_b[2]}, 32'd1);
        settle();

        // 4: ack in the same cycle as a new event
        asynch[3] = 1'b1;
        steps(6);
        check_val("t4_pending_first", {31'd0, pending_a[3]}, 32'd1);
        asynch[3] = 1'b0;
        steps(4);
        asynch[3] = 1'b1;
        steps(3);
        ack[3] = 1'b1;
        step();
        check_val("t4_pulse",   {31'd0, pulse_a[3]},   32'd1);
        check_val("t4_pending", {31'd0, pending_a[3]}, 32'd1);
        check_val("t4_overrun", {31'd0, overrun_a[3]}, 32'd0);
        step();
        ack[3] = 1'b0;
        check_val("t4_ack_clears", {31'd0, pending_a[3]}, 32'd0);
        asynch[3] = 1'b0;
        settle();

        // 5: edge during enable=0 is lost; next edge fires once
        base0 = pc_a[0];
        enable = 1'b0;
        asynch[0] = 1'b1;
        steps(6);
        enable = 1'b1;
        steps(6);
        check_val("t5_disabled_pulses",  pc_a[0] - base0, 32'd0);
        check_val("t5_disabled_pending", {31'd0, pending_a[0]}, 32'd0);
        asynch[0] = 1'b0;
        steps(6);
        asynch[0] = 1'b1;
        steps(6);
        check_val("t5_enabled_pulses", pc_a[0] - base0, 32'd1);
        asynch[0] = 1'b0;
        settle();

        // 6: reset mid-debounce and mid-pending
        asynch[1] = 1'b1;
        steps(10);
        check_val("t6_pending_b1", {31'd0, pending_b[1]}, 32'd1);
        asynch[0] = 1'b1;
        steps(3);
        rst = 1'b0;
        asynch[1] = 1'b0;
        step();
        check_val("t6_rst_a", {16'd0, synch_a, pulse_a, pending_a, overrun_a}, 32'd0);
        check_val("t6_rst_b", {16'd0, synch_b, pulse_b, pending_b, overrun_b}, 32'd0);
        rst = 1'b1;
        base0 = pc_b[0]; base1 = pc_b[1]; base2 = pc_a[0];
        steps(20);
        check_val("t6_b0_event",    pc_b[0] - base0, 32'd1);
        check_val("t6_b1_no_stray", pc_b[1] - base1, 32'd0);
        check_val("t6_a0_event",    pc_a[0] - base2, 32'd1);
        asynch[0] = 1'b0;
        settle();

        // Random traffic, checked by the scoreboard each cycle.
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) asynch[b] = ~asynch[b];
            end
            ack         = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            enable      = ($urandom_range(0, 9) != 0);
            overrun_clr = ($urandom_range(0, 9) == 0);
            rst         = ($urandom_range(0, 99) != 0);
            step();
        end
        rst = 1'b1; enable = 1'b1; ack = 4'h0; overrun_clr = 1'b0; asynch = 4'h0;
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
